// File: rtl/xpmwrap_sdpram_be_pkg.sv
// Shared types and elaboration helpers for the byte-enable simple dual-port RAM wrapper.
package xpmwrap_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int nb_calc(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic bit params_ok(input int read_latency, input int data_width,
                                   input int byte_width);
    return (read_latency >= 1) && (read_latency <= 3) && (byte_width > 0) &&
           ((data_width % byte_width) == 0);
  endfunction

endpackage

// File: rtl/xpmwrap_sdpram_be_delay.sv
// Valid+data delay line with synchronous active-low clear; STAGES must be at least 1.
module xpmwrap_delay #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  dat_q [STAGES];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[STAGES-1];
  assign data_o  = dat_q[STAGES-1];

endmodule

// File: rtl/xpmwrap_sdpram_be.sv
// Single-clock SDP RAM with byte enables, read latency 1..3 and a post-reset clear sweep.
// Define XPMWRAP_SDPRAM_BE_BYPASS_EN for per-byte write-first on same-address collisions.
module xpmwrap_sdpram_be
  import xpmwrap_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 6,
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  BYTE_WIDTH     = 8,
  parameter int                  READ_LATENCY   = 2,
  parameter int                  CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          wr_en,
  input  logic [ADDR_WIDTH-1:0]                         wr_addr,
  input  logic [nb_calc(DATA_WIDTH, BYTE_WIDTH)-1:0]    wr_be,
  input  logic [DATA_WIDTH-1:0]                         wr_data,
  input  logic                                          rd_en,
  input  logic [ADDR_WIDTH-1:0]                         rd_addr,
  output logic [DATA_WIDTH-1:0]                         rd_data,
  output logic                                          rd_valid,
  output logic                                          busy,
  output logic                                          drop_err
);

  localparam int NB    = nb_calc(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  if (!params_ok(READ_LATENCY, DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_params
    $error("xpmwrap_sdpram_be: READ_LATENCY must be 1..3 and DATA_WIDTH a multiple of BYTE_WIDTH");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  drop_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rd_acc, wr_acc, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata, rd_word;
  logic                  dl_valid;
  logic [DATA_WIDTH-1:0] dl_data;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (!rstn) begin
      state_d = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      sweep_d = '0;
    end else if (state_q == CLEAR) begin
      if (sweep_q == LAST_ADDR) state_d = READY;
      else                      sweep_d = sweep_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    sweep_q <= sweep_d;
  end

  assign busy   = (state_q == CLEAR);
  assign rd_acc = rstn && (state_q == READY) && rd_en;
  assign wr_acc = rstn && (state_q == READY) && wr_en;

  // The sweep owns the write port while busy; user writes only land in READY.
  always_comb begin
    mem_we    = wr_acc;
    mem_addr  = wr_addr;
    mem_be    = wr_be;
    mem_wdata = wr_data;
    if (rstn && (state_q == CLEAR)) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_q;
      mem_be    = '1;
      mem_wdata = CLEAR_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem_q[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = mem_q[rd_addr];
`ifdef XPMWRAP_SDPRAM_BE_BYPASS_EN
    if (wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
`endif
  end

  if (READ_LATENCY > 1) begin : g_delay
    xpmwrap_delay #(
      .STAGES (READ_LATENCY - 1),
      .WIDTH  (DATA_WIDTH)
    ) u_delay (
      .clk     (clk),
      .rstn    (rstn),
      .valid_i (rd_acc),
      .data_i  (rd_word),
      .valid_o (dl_valid),
      .data_o  (dl_data)
    );
  end else begin : g_nodelay
    assign dl_valid = rd_acc;
    assign dl_data  = rd_word;
  end

  // Output register holds the last returned word between beats.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      rd_valid_q <= dl_valid;
      if (dl_valid) rd_data_q <= dl_data;
      if ((state_q == CLEAR) && (rd_en || wr_en)) drop_q <= 1'b1;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_xpmwrap_sdpram_be.sv
// Bench for xpmwrap_sdpram_be: three latencies driven in parallel against a history-based model.
module tb_xpmwrap_sdpram_be;

  localparam int DEPTH = 64;
  localparam int MAXC  = 8192;

  logic        clk = 1'b0;
  logic        rstn, wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  logic        rdv [3];
  logic [31:0] rdd [3];
  logic        bsy [3];
  logic        drp [3];

  int n_cmp = 0;
  int n_bad = 0;
  int beats [3];

  always #5 clk = ~clk;

  xpmwrap_sdpram_be #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rdv[0]), .busy(bsy[0]), .drop_err(drp[0]));
  xpmwrap_sdpram_be #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rdv[1]), .busy(bsy[1]), .drop_err(drp[1]));
  xpmwrap_sdpram_be #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_valid(rdv[2]), .busy(bsy[2]), .drop_err(drp[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-edge history of accepted reads and resets.
  bit          started = 1'b0;
  int          cyc = 0;
  int          busy_left = 0;
  bit          drop_m = 1'b0;
  logic [31:0] mem_m [DEPTH];
  bit          acc_h [MAXC];
  bit          rst_h [MAXC];
  logic [31:0] rdw_h [MAXC];
  bit          exp_v [3];
  logic [31:0] exp_d [3];

  always @(posedge clk) begin
    logic [31:0] w;
    int k;
    bit v;
    if (cyc < MAXC) begin
      rst_h[cyc] = !rstn;
      acc_h[cyc] = 1'b0;
      rdw_h[cyc] = '0;
      if (!rstn) begin
        started   = 1'b1;
        busy_left = DEPTH;
        drop_m    = 1'b0;
      end else if (busy_left > 0) begin
        if (rd_en || wr_en) drop_m = 1'b1;
        mem_m[DEPTH - busy_left] = 32'h0;
        busy_left--;
      end else begin
        if (rd_en) begin
          w = mem_m[rd_addr];
`ifdef XPMWRAP_SDPRAM_BE_BYPASS_EN
          if (wr_en && (wr_addr == rd_addr))
            for (int b = 0; b < 4; b++) if (wr_be[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
`endif
          acc_h[cyc] = 1'b1;
          rdw_h[cyc] = w;
        end
        if (wr_en)
          for (int b = 0; b < 4; b++) if (wr_be[b]) mem_m[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
      end
      for (int l = 0; l < 3; l++) begin
        k = cyc - l;
        v = (k >= 0) && acc_h[k];
        for (int j = k + 1; j <= cyc; j++) if (j >= 0 && rst_h[j]) v = 1'b0;
        if (rst_h[cyc]) begin
          exp_v[l] = 1'b0;
          exp_d[l] = '0;
        end else begin
          exp_v[l] = v;
          if (v) exp_d[l] = rdw_h[k];
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int l = 0; l < 3; l++) begin
        chk($sformatf("busy_L%0d", l + 1), {31'b0, bsy[l]}, {31'b0, busy_left > 0});
        chk($sformatf("drop_err_L%0d", l + 1), {31'b0, drp[l]}, {31'b0, drop_m});
        chk($sformatf("rd_valid_L%0d", l + 1), {31'b0, rdv[l]}, {31'b0, exp_v[l]});
        chk($sformatf("rd_data_L%0d", l + 1), rdd[l], exp_d[l]);
        if (rdv[l] === 1'b1) beats[l]++;
      end
    end
  end

  task automatic idle(input int n);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input bit r, input logic [5:0] ra, input bit w, input logic [5:0] wa,
                     input logic [3:0] be, input logic [31:0] d);
    rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_be = be; wr_data = d;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_beat(input string nm, input logic [31:0] exp);
    int n = 0;
    while (rdv[1] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    if (rdv[1] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no rd_valid within 10 cycles, want %h", nm, exp);
    end else chk(nm, rdd[1], exp);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bsy[1] !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (bsy[1] !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ready: busy still %b after 200 cycles, want 0", bsy[1]);
    end
  endtask

  task automatic pulse_reset(input int n);
    rstn = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    repeat (n) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    rstn = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    for (int l = 0; l < 3; l++) beats[l] = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Sweep length and cleared contents.
    n = 0;
    while (bsy[1] === 1'b1 && n < 200) begin n++; @(negedge clk); end
    chk("sweep_busy_cycles", n, 64);
    for (int a = 0; a < 4; a++) begin
      req(1'b1, 6'(a * 17), 1'b0, '0, '0, '0);
      wait_beat("cleared_word", 32'h0);
    end

    // Byte-lane merge.
    req(1'b0, '0, 1'b1, 6'd5, 4'b1111, 32'hDEADBEEF);
    req(1'b0, '0, 1'b1, 6'd5, 4'b0010, 32'h0000AA00);
    req(1'b1, 6'd5, 1'b0, '0, '0, '0);
    wait_beat("byte_merge", 32'hDEADAAEF);
    req(1'b0, '0, 1'b1, 6'd5, 4'b0000, 32'h12345678);
    req(1'b1, 6'd5, 1'b0, '0, '0, '0);
    wait_beat("be_zero_no_change", 32'hDEADAAEF);

    // Back-to-back reads across all three latencies.
    for (int a = 0; a < 8; a++) req(1'b0, '0, 1'b1, 6'(a), 4'hF, 32'hA0 + a);
    for (int l = 0; l < 3; l++) beats[l] = 0;
    for (int a = 0; a < 8; a++) req(1'b1, 6'(a), 1'b0, '0, '0, '0);
    idle(6);
    for (int l = 0; l < 3; l++) chk($sformatf("b2b_beats_L%0d", l + 1), beats[l], 8);
    chk("b2b_last_word", rdd[1], 32'hA7);

    // Same-address collision.
    req(1'b0, '0, 1'b1, 6'd9, 4'hF, 32'h11111111);
    req(1'b1, 6'd9, 1'b1, 6'd9, 4'b0011, 32'h22222222);
`ifdef XPMWRAP_SDPRAM_BE_BYPASS_EN
    wait_beat("collision", 32'h11112222);
`else
    wait_beat("collision", 32'h11111111);
`endif
    req(1'b1, 6'd9, 1'b0, '0, '0, '0);
    wait_beat("post_collision", 32'h11112222);

    // Requests during the sweep are dropped.
    pulse_reset(1);
    chk("drop_cleared", {31'b0, drp[1]}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    req(1'b1, 6'd1, 1'b1, 6'd1, 4'hF, 32'hFFFFFFFF);
    chk("drop_set", {31'b0, drp[1]}, 32'h1);
    wait_ready();
    chk("drop_sticky", {31'b0, drp[1]}, 32'h1);
    req(1'b1, 6'd1, 1'b0, '0, '0, '0);
    wait_beat("dropped_write_absent", 32'h0);

    // Reset one cycle after a read.
    req(1'b1, 6'd3, 1'b0, '0, '0, '0);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_drop", {31'b0, drp[1]}, 32'h0);
    chk("midreset_busy", {31'b0, bsy[1]}, 32'h1);
    chk("midreset_valid", {31'b0, rdv[1]}, 32'h0);
    rstn = 1'b1;
    idle(4);
    chk("midreset_no_beat", {31'b0, rdv[1]}, 32'h0);
    wait_ready();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rstn    = ($urandom_range(0, 399) != 0);
      rd_en   = $urandom_range(0, 1);
      wr_en   = $urandom_range(0, 1);
      rd_addr = 6'($urandom_range(0, 15));
      wr_addr = 6'($urandom_range(0, 15));
      wr_be   = 4'($urandom);
      wr_data = $urandom;
      @(negedge clk);
    end
    rstn = 1'b1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
